mem_arbiter_rr: RTL

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_rr_picker.sv | 50 +++++
 rtl/mem_arbiter_rr.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared FSM state encoding and arbitration-mode constants.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    function automatic arb_mode_e mode_from_param(input int mode);
        return (mode == ARB_MODE_FIXED) ? ARB_FIXED : ARB_RR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational winner select, fixed-priority or round-robin.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  arb_mode_e          mode,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int               start;
    int               cand;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the ports once starting at the search origin; first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        start     = (mode == ARB_RR) ? int'(ptr) : 0;
        cand      = 0;
        idx       = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = start + i;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            idx = IDX_W'(cand);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
// ============================================================================
//  Module      : mem_arbiter_rr
//  Description : N-port memory arbiter with IDLE/BUSY/DONE FSM and watchdog.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int ARB_MODE = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          we,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    output logic [N_PORTS-1:0]          ack,
    output logic [N_PORTS-1:0]          err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_enable,
    output logic                        mem_rw,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data_in,
    input  logic [DATA_W-1:0]           mem_data_out,
    input  logic                        mem_ack
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam arb_mode_e        PICK_MODE = mode_from_param(ARB_MODE);

    arb_state_e         state;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   busy_cnt;
    logic [N_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               timeout_hit;

    rr_picker #(
        .N_PORTS   (N_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr),
        .mode      (PICK_MODE),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    assign next_ptr    = (winner == LAST_PORT) ? '0 : winner + 1'b1;
    // Fires on the last allowed BUSY cycle; mem_ack in that cycle still takes priority.
    assign timeout_hit = (TIMEOUT > 0) && (busy_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            winner      <= '0;
            ptr         <= '0;
            busy_cnt    <= '0;
            ack         <= '0;
            err         <= '0;
            rdata       <= '0;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                ST_IDLE: begin
                    if (|pick_grant) begin
                        winner      <= pick_idx;
                        mem_rw      <= we[pick_idx];
                        mem_addr    <= addr[pick_idx*ADDR_W +: ADDR_W];
                        mem_data_in <= wdata[pick_idx*DATA_W +: DATA_W];
                        mem_enable  <= 1'b1;
                        busy_cnt    <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        if (!mem_rw) begin
                            rdata <= mem_data_out;
                        end
                        ack[winner] <= 1'b1;
                        mem_enable  <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= ST_DONE;
                    end else if (timeout_hit) begin
                        err[winner] <= 1'b1;
                        mem_enable  <= 1'b0;
                        ptr         <= next_ptr;
                        busy_cnt    <= busy_cnt + 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        busy_cnt    <= busy_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
